// File: rtl/rf_wr_sched.sv
// Write-port scheduler: two one-entry writeback slots (ALU, load) sharing one register-file write port.
// Optional macro RF_WR_BYPASS_EN adds read bypass from the output stage and drops it from busyA/busyB.
module rf_wr_sched #(
    parameter int PW = 3,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DW-1:0]     alu_data,
    input  logic [PW-1:0]     alu_addr,
    input  logic              alu_inplace,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [DW-1:0]     mem_data,
    input  logic [PW-1:0]     mem_addr,
    input  logic              mem_inplace,
    output logic              rf_wr_en,
    output logic              rf_in_place,
    output logic [PW-1:0]     rf_wr_addr,
    output logic [DW-1:0]     rf_dat_in,
    input  logic [PW-1:0]     rd_addrA,
    input  logic [PW-1:0]     rd_addrB,
    output logic              busyA,
    output logic              busyB,
    output logic [2**PW-1:0]  pending,
    output logic              fwdA_valid,
    output logic              fwdB_valid,
    output logic [DW-1:0]     fwdA_data,
    output logic [DW-1:0]     fwdB_data
);
    localparam int NR = 2**PW;

    logic              alu_full_q, alu_full_d, mem_full_q, mem_full_d;
    logic [PW-1:0]     alu_ea_q, alu_ea_d, mem_ea_q, mem_ea_d;
    logic [DW-1:0]     alu_data_q, mem_data_q;
    logic              alu_inp_q, mem_inp_q;
    logic              mem_older_q, mem_older_d;
    logic              last_mem_q, last_mem_d;
    logic              wr_en_q, wr_en_d, wr_inp_q, wr_inp_d;
    logic [PW-1:0]     wr_addr_q, wr_addr_d;
    logic [DW-1:0]     wr_dat_q, wr_dat_d;
    logic              alu_cap, mem_cap, gnt_alu, gnt_mem;
    logic [NR-1:0]     pend_slots;

    assign alu_ready = !alu_full_q;
    assign mem_ready = !mem_full_q;
    assign alu_cap   = alu_valid && !alu_full_q;
    assign mem_cap   = mem_valid && !mem_full_q;
    assign alu_ea_d  = alu_inplace ? alu_addr : '0;
    assign mem_ea_d  = mem_inplace ? mem_addr : '0;

    // Same destination keeps capture order; otherwise the last-granted source yields.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (alu_full_q && mem_full_q) begin
            if (alu_ea_q == mem_ea_q) begin
                gnt_mem = mem_older_q;
                gnt_alu = !mem_older_q;
            end else begin
                gnt_alu = last_mem_q;
                gnt_mem = !last_mem_q;
            end
        end else begin
            gnt_alu = alu_full_q;
            gnt_mem = mem_full_q;
        end
    end

    always_comb begin
        alu_full_d  = alu_cap || (alu_full_q && !gnt_alu);
        mem_full_d  = mem_cap || (mem_full_q && !gnt_mem);
        mem_older_d = mem_older_q;
        if (alu_cap)      mem_older_d = 1'b1;
        else if (mem_cap) mem_older_d = 1'b0;
        last_mem_d  = last_mem_q;
        if (gnt_mem)      last_mem_d = 1'b1;
        else if (gnt_alu) last_mem_d = 1'b0;
        wr_en_d     = gnt_alu || gnt_mem;
        wr_addr_d   = wr_addr_q;
        wr_dat_d    = wr_dat_q;
        wr_inp_d    = wr_inp_q;
        if (gnt_mem) begin
            wr_addr_d = mem_ea_q;
            wr_dat_d  = mem_data_q;
            wr_inp_d  = mem_inp_q;
        end else if (gnt_alu) begin
            wr_addr_d = alu_ea_q;
            wr_dat_d  = alu_data_q;
            wr_inp_d  = alu_inp_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_full_q  <= 1'b0;
            mem_full_q  <= 1'b0;
            mem_older_q <= 1'b0;
            last_mem_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_dat_q    <= '0;
            wr_inp_q    <= 1'b0;
        end else begin
            alu_full_q  <= alu_full_d;
            mem_full_q  <= mem_full_d;
            mem_older_q <= mem_older_d;
            last_mem_q  <= last_mem_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_dat_q    <= wr_dat_d;
            wr_inp_q    <= wr_inp_d;
        end
    end

    // Slot payload is qualified by the full flags, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alu_cap) begin
            alu_ea_q   <= alu_ea_d;
            alu_data_q <= alu_data;
            alu_inp_q  <= alu_inplace;
        end
        if (mem_cap) begin
            mem_ea_q   <= mem_ea_d;
            mem_data_q <= mem_data;
            mem_inp_q  <= mem_inplace;
        end
    end

    assign rf_wr_en    = wr_en_q;
    assign rf_wr_addr  = wr_addr_q;
    assign rf_dat_in   = wr_dat_q;
    assign rf_in_place = wr_inp_q;

    always_comb begin
        pend_slots = '0;
        pending    = '0;
        for (int i = 0; i < NR; i++) begin
            pend_slots[i] = (alu_full_q && alu_ea_q == PW'(i)) || (mem_full_q && mem_ea_q == PW'(i));
            pending[i]    = pend_slots[i] || (wr_en_q && wr_addr_q == PW'(i));
        end
    end

`ifdef RF_WR_BYPASS_EN
    assign fwdA_valid = wr_en_q && (wr_addr_q == rd_addrA);
    assign fwdB_valid = wr_en_q && (wr_addr_q == rd_addrB);
    assign fwdA_data  = fwdA_valid ? wr_dat_q : '0;
    assign fwdB_data  = fwdB_valid ? wr_dat_q : '0;
    assign busyA      = pend_slots[rd_addrA];
    assign busyB      = pend_slots[rd_addrB];
`else
    assign fwdA_valid = 1'b0;
    assign fwdB_valid = 1'b0;
    assign fwdA_data  = '0;
    assign fwdB_data  = '0;
    assign busyA      = pending[rd_addrA];
    assign busyB      = pending[rd_addrB];
`endif

endmodule

// File: tb/tb_rf_wr_sched.sv
// Bench for rf_wr_sched: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rf_wr_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_valid, alu_inplace, mem_valid, mem_inplace;
    logic [7:0] alu_data, mem_data;
    logic [2:0] alu_addr, mem_addr, rd_addrA, rd_addrB;
    logic       alu_ready, mem_ready, rf_wr_en, rf_in_place, busyA, busyB;
    logic [2:0] rf_wr_addr;
    logic [7:0] rf_dat_in, pending, fwdA_data, fwdB_data;
    logic       fwdA_valid, fwdB_valid;

    rf_wr_sched #(.PW(3), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data),
        .alu_addr(alu_addr), .alu_inplace(alu_inplace),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
        .mem_addr(mem_addr), .mem_inplace(mem_inplace),
        .rf_wr_en(rf_wr_en), .rf_in_place(rf_in_place), .rf_wr_addr(rf_wr_addr),
        .rf_dat_in(rf_dat_in), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .busyA(busyA), .busyB(busyB), .pending(pending),
        .fwdA_valid(fwdA_valid), .fwdB_valid(fwdB_valid),
        .fwdA_data(fwdA_data), .fwdB_data(fwdB_data)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: index 0 = ALU, 1 = load; age kept as capture timestamps.
    bit       m_full[2];
    bit [2:0] m_ea[2];
    bit [7:0] m_dat[2];
    bit       m_inp[2];
    int       m_seq[2];
    int       stamp;
    int       m_last;
    bit       m_en, m_wip;
    bit [2:0] m_addr;
    bit [7:0] m_wd;
    bit [7:0] m_rf[8];
    bit [7:0] rf_mirror[8];
    bit       acc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_last = 1; m_en = 0; m_addr = 0; m_wd = 0; m_wip = 0;
        acc[0] = 0; acc[1] = 0;
    endtask

    task automatic model_edge();
        int g;
        bit c0, c1;
        c0 = alu_valid && !m_full[0];
        c1 = mem_valid && !m_full[1];
        g = -1;
        if (m_full[0] && m_full[1]) begin
            if (m_ea[0] == m_ea[1]) g = (m_seq[0] < m_seq[1]) ? 0 : 1;
            else                    g = (m_last == 0) ? 1 : 0;
        end else if (m_full[0]) g = 0;
        else if (m_full[1])     g = 1;
        if (m_en) m_rf[m_addr] = m_wd;
        if (g >= 0) begin
            m_en = 1; m_addr = m_ea[g]; m_wd = m_dat[g]; m_wip = m_inp[g];
            m_full[g] = 0; m_last = g;
        end else m_en = 0;
        if (c1) begin
            m_full[1] = 1; m_ea[1] = mem_inplace ? mem_addr : 3'd0;
            m_dat[1] = mem_data; m_inp[1] = mem_inplace; m_seq[1] = stamp++;
        end
        if (c0) begin
            m_full[0] = 1; m_ea[0] = alu_inplace ? alu_addr : 3'd0;
            m_dat[0] = alu_data; m_inp[0] = alu_inplace; m_seq[0] = stamp++;
        end
        acc[0] = c0; acc[1] = c1;
    endtask

    task automatic check_all();
        bit [7:0] sp, ep;
        bit       bypass;
        bit       fa, fb;
`ifdef RF_WR_BYPASS_EN
        bypass = 1;
`else
        bypass = 0;
`endif
        for (int i = 0; i < 8; i++) begin
            sp[i] = (m_full[0] && m_ea[0] == i) || (m_full[1] && m_ea[1] == i);
            ep[i] = sp[i] || (m_en && m_addr == i);
        end
        fa = bypass && m_en && m_addr == rd_addrA;
        fb = bypass && m_en && m_addr == rd_addrB;
        chk("rf_wr_en", rf_wr_en, m_en);
        chk("rf_wr_addr", rf_wr_addr, m_addr);
        chk("rf_dat_in", rf_dat_in, m_wd);
        chk("rf_in_place", rf_in_place, m_wip);
        chk("alu_ready", alu_ready, !m_full[0]);
        chk("mem_ready", mem_ready, !m_full[1]);
        chk("pending", pending, ep);
        chk("busyA", busyA, bypass ? sp[rd_addrA] : ep[rd_addrA]);
        chk("busyB", busyB, bypass ? sp[rd_addrB] : ep[rd_addrB]);
        chk("fwdA_valid", fwdA_valid, fa);
        chk("fwdB_valid", fwdB_valid, fb);
        chk("fwdA_data", fwdA_data, fa ? m_wd : 8'h00);
        chk("fwdB_data", fwdB_data, fb ? m_wd : 8'h00);
    endtask

    task automatic cycle();
        if (rf_wr_en) rf_mirror[rf_wr_addr] = rf_dat_in;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_alu(input bit v, input bit [2:0] a, input bit ip, input bit [7:0] d);
        alu_valid = v; alu_addr = a; alu_inplace = ip; alu_data = d;
    endtask

    task automatic set_mem(input bit v, input bit [2:0] a, input bit ip, input bit [7:0] d);
        mem_valid = v; mem_addr = a; mem_inplace = ip; mem_data = d;
    endtask

    initial begin
        bit prev_ar;
        stamp = 0;
        for (int i = 0; i < 8; i++) begin m_rf[i] = 0; rf_mirror[i] = 0; end
        rst_n = 1'b0;
        set_alu(0, 0, 0, 0); set_mem(0, 0, 0, 0);
        rd_addrA = 3'd3; rd_addrB = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", rf_wr_en, 1'b0);
        chk("rst_wr_addr", rf_wr_addr, 3'd0);
        chk("rst_dat_in", rf_dat_in, 8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_busyA", busyA, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        cycle();
        chk("rel_alu_ready", alu_ready, 1'b1);
        chk("rel_mem_ready", mem_ready, 1'b1);

        // ALU write to r3 with latency two edges after capture
        set_alu(1, 3'd3, 1, 8'h5A);
        cycle();
        chk("t1_pend3_cap", pending[3], 1'b1);
        chk("t1_en_cap", rf_wr_en, 1'b0);
        set_alu(0, 0, 0, 0);
        cycle();
        chk("t1_en", rf_wr_en, 1'b1);
        chk("t1_addr", rf_wr_addr, 3'd3);
        chk("t1_data", rf_dat_in, 8'h5A);
        chk("t1_pend3_out", pending[3], 1'b1);
        cycle();
        chk("t1_en_off", rf_wr_en, 1'b0);
        chk("t1_pend3_done", pending[3], 1'b0);

        // inplace=0 redirects to r0
        set_alu(1, 3'd5, 0, 8'h11);
        cycle();
        chk("t2_pend0", pending[0], 1'b1);
        chk("t2_pend5", pending[5], 1'b0);
        set_alu(0, 0, 0, 0);
        cycle();
        chk("t2_addr", rf_wr_addr, 3'd0);
        chk("t2_inplace", rf_in_place, 1'b0);
        cycle();

        // Same-edge capture to the same register: load lands first
        set_alu(1, 3'd2, 1, 8'hBB); set_mem(1, 3'd2, 1, 8'hAA);
        cycle();
        set_alu(0, 0, 0, 0); set_mem(0, 0, 0, 0);
        cycle();
        chk("t3_first", rf_dat_in, 8'hAA);
        cycle();
        chk("t3_second", rf_dat_in, 8'hBB);
        cycle(); cycle();
        chk("t3_r2", rf_mirror[2], 8'hBB);

        // Both sources streaming to distinct registers
        set_alu(1, 3'd1, 1, 8'h01); set_mem(1, 3'd4, 1, 8'h80);
        prev_ar = 0;
        for (int k = 0; k < 14; k++) begin
            cycle();
            if (k >= 1) begin
                chk("t4_en", rf_wr_en, 1'b1);
                chk("t4_rdy_excl", alu_ready ^ mem_ready, 1'b1);
            end
            if (k >= 2) chk("t4_toggle", alu_ready, !prev_ar);
            prev_ar = alu_ready;
            if (acc[0]) set_alu(1, 3'(1 + k % 3), 1, 8'(k + 8'h10));
            if (acc[1]) set_mem(1, 3'(4 + k % 4), 1, 8'(k + 8'hC0));
        end
        set_alu(0, 0, 0, 0); set_mem(0, 0, 0, 0);
        repeat (4) cycle();

        // Reset while both slots hold writes
        set_alu(1, 3'd6, 1, 8'h66); set_mem(1, 3'd7, 1, 8'h77);
        rd_addrA = 3'd6;
        cycle();
        set_alu(0, 0, 0, 0); set_mem(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_en", rf_wr_en, 1'b0);
        chk("t5_pending", pending, 8'h00);
        chk("t5_busyA", busyA, 1'b0);
        chk("t5_alu_ready", alu_ready, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) cycle();

        // Output-stage bypass to read port A
        rd_addrA = 3'd4;
        set_alu(1, 3'd4, 1, 8'h3C);
        cycle();
        set_alu(0, 0, 0, 0);
        cycle();
`ifdef RF_WR_BYPASS_EN
        chk("t6_fwdA_valid", fwdA_valid, 1'b1);
        chk("t6_fwdA_data", fwdA_data, 8'h3C);
        chk("t6_busyA", busyA, 1'b0);
`else
        chk("t6_busyA", busyA, 1'b1);
        chk("t6_fwdA_valid", fwdA_valid, 1'b0);
        chk("t6_fwdA_data", fwdA_data, 8'h00);
`endif
        cycle();

        // Randomized traffic obeying the hold-until-ready rule
        for (int k = 0; k < 500; k++) begin
            if (!alu_valid || acc[0])
                set_alu($urandom_range(0, 9) < 6, 3'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));
            if (!mem_valid || acc[1])
                set_mem($urandom_range(0, 9) < 6, 3'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));
            rd_addrA = 3'($urandom);
            rd_addrB = 3'($urandom);
            cycle();
        end
        set_alu(0, 0, 0, 0); set_mem(0, 0, 0, 0);
        repeat (4) cycle();
        for (int i = 0; i < 8; i++) chk("final_rf", rf_mirror[i], m_rf[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
